// File: rtl/full_adder_pkg.sv
// Shared constants for the ripple-carry adder slice.
// Holds the value loaded into the registered outputs on reset.
package full_adder_pkg;

    localparam logic RST_VAL = 1'b0;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full-adder cell; WIDTH copies chained by carry form the ripple adder.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder.sv
// Parameterizable ripple-carry adder with a combinational result and a
// one-cycle registered copy qualified by a valid flag.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic             x,
    output logic [WIDTH-1:0] y_q,
    output logic             x_q,
    output logic             out_valid
);

    logic [WIDTH:0]   k;
    logic [WIDTH-1:0] y_d;
    logic             x_d;

    assign k[0] = c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_bit u_bit (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (k[i]),
            .s    (y[i]),
            .cout (k[i+1])
        );
    end

    assign x = k[WIDTH];

    // Result registers hold their contents whenever no new operand is qualified.
    assign y_d = in_valid ? y : y_q;
    assign x_d = in_valid ? x : x_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q       <= {WIDTH{RST_VAL}};
            x_q       <= RST_VAL;
            out_valid <= 1'b0;
        end else begin
            y_q       <= y_d;
            x_q       <= x_d;
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder at WIDTH=1 and WIDTH=8 with a result scoreboard.
module tb_full_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       a1, b1, c1, v1;
    logic       y1, x1, yq1, xq1, ov1;
    logic [7:0] a8, b8, y8, yq8;
    logic       c8, v8, x8, xq8, ov8;

    int passed = 0;
    int total  = 0;

    logic [1:0] q1[$];
    logic [8:0] q8[$];
    logic [1:0] h1;
    logic [8:0] h8;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .in_valid(v1),
        .y(y1), .x(x1), .y_q(yq1), .x_q(xq1), .out_valid(ov1)
    );

    full_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .in_valid(v8),
        .y(y8), .x(x8), .y_q(yq8), .x_q(xq8), .out_valid(ov8)
    );

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [1:0] model1(input logic a, input logic b, input logic c);
        logic [1:0] r;
        r = {1'b0, a} + {1'b0, b} + {1'b0, c};
        return r;
    endfunction

    function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] r;
        r = {1'b0, a} + {1'b0, b} + {8'b0, c};
        return r;
    endfunction

    task automatic comb_chk();
        logic [1:0] r1;
        logic [8:0] r8;
        r1 = model1(a1, b1, c1);
        r8 = model8(a8, b8, c8);
        chk("y1", {8'b0, y1}, {8'b0, r1[0]});
        chk("x1", {8'b0, x1}, {8'b0, r1[1]});
        chk("y8", {1'b0, y8}, {1'b0, r8[7:0]});
        chk("x8", {8'b0, x8}, {8'b0, r8[8]});
    endtask

    // Push expected results for qualified operands, advance one edge, compare.
    task automatic step();
        logic e1, e8;
        e1 = v1 && !rst;
        e8 = v8 && !rst;
        if (e1) q1.push_back(model1(a1, b1, c1));
        if (e8) q8.push_back(model8(a8, b8, c8));
        @(posedge clk);
        #1;
        chk("ov1", {8'b0, ov1}, {8'b0, e1});
        chk("ov8", {8'b0, ov8}, {8'b0, e8});
        if (e1 && q1.size() > 0) h1 = q1.pop_front();
        if (e8 && q8.size() > 0) h8 = q8.pop_front();
        chk("yq1", {8'b0, yq1}, {8'b0, h1[0]});
        chk("xq1", {8'b0, xq1}, {8'b0, h1[1]});
        chk("yq8", {1'b0, yq8}, {1'b0, h8[7:0]});
        chk("xq8", {8'b0, xq8}, {8'b0, h8[8]});
    endtask

    task automatic reset_chk();
        chk("rst_ov1", {8'b0, ov1}, 9'd0);
        chk("rst_yq1", {8'b0, yq1}, 9'd0);
        chk("rst_xq1", {8'b0, xq1}, 9'd0);
        chk("rst_ov8", {8'b0, ov8}, 9'd0);
        chk("rst_yq8", {1'b0, yq8}, 9'd0);
        chk("rst_xq8", {8'b0, xq8}, 9'd0);
    endtask

    initial begin
        rst = 1'b1;
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0; v1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; c8 = 1'b0; v8 = 1'b0;
        h1 = '0;
        h8 = '0;
        #1;
        reset_chk();

        // WIDTH=1 truth table sweep; combinational path must follow during reset.
        for (int i = 0; i < 8; i++) begin
            {a1, b1, c1} = 3'(i);
            #5;
            comb_chk();
        end
        chk("tt011_y", {8'b0, model1(1'b0, 1'b1, 1'b1)}, {7'b0, 2'b10});
        a1 = 1'b0; b1 = 1'b1; c1 = 1'b1;
        #1;
        chk("tt011_dut", {7'b0, x1, y1}, {7'b0, 2'b10});
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        #1;
        chk("tt111_dut", {7'b0, x1, y1}, {7'b0, 2'b11});

        a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; #1;
        chk("w8_ff01", {x8, y8}, 9'h100);
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; #1;
        chk("w8_ffff1", {x8, y8}, 9'h1FF);
        a8 = 8'h3C; b8 = 8'h42; c8 = 1'b1; #1;
        chk("w8_3c42", {x8, y8}, 9'h07F);

        // Release reset with a qualified operand already waiting.
        @(posedge clk);
        #1;
        rst = 1'b0;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b0; v1 = 1'b1;
        a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; v8 = 1'b1;
        step();
        chk("rel_q1", {7'b0, xq1, yq1}, {7'b0, 2'b10});

        a1 = 1'b1; b1 = 1'b0; c1 = 1'b1;
        step();
        chk("abc101_q1", {7'b0, xq1, yq1}, {7'b0, 2'b10});
        v1 = 1'b0; v8 = 1'b0;
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00;
        step();

        // Back-to-back qualified operands.
        v1 = 1'b1; v8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
                a8 = 8'h3C; b8 = 8'h42; c8 = 1'b1;
            end else begin
                a1 = 1'($urandom_range(0, 1));
                b1 = 1'($urandom_range(0, 1));
                c1 = 1'($urandom_range(0, 1));
                a8 = 8'($urandom_range(0, 255));
                b8 = 8'($urandom_range(0, 255));
                c8 = 1'($urandom_range(0, 1));
            end
            #1;
            comb_chk();
            step();
        end
        chk("b2b_last8", {xq8, yq8}, 9'h07F);

        // Asynchronous reset between edges while outputs hold valid nonzero data.
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        a1 = 1'b0; b1 = 1'b1; c1 = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        reset_chk();
        comb_chk();
        h1 = '0;
        h8 = '0;
        q1.delete();
        q8.delete();
        step();

        #1;
        rst = 1'b0;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
        step();
        chk("rel2_q1", {7'b0, xq1, yq1}, {7'b0, 2'b10});
        chk("rel2_q8", {xq8, yq8}, 9'h1FF);
        v1 = 1'b0; v8 = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Parameterizable ripple-carry full adder: adds operands a and b plus carry-in c.
- Produces sum y and carry-out x combinationally.
- Also provides a registered copy of the result (y_q, x_q) with a valid flag, for pipelined datapaths.
- With WIDTH=1 it is the classic 1-bit full adder: 3 inputs, sum and carry outputs.

Parameters:
- WIDTH, 1, operand/sum width in bits (legal range 1..64).

Ports:
- clk  input  1  single system clock, rising-edge active.
- rst  input  1  reset, asynchronous and active-high; clears all registered outputs.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c  input  1  carry-in.
- in_valid  input  1  qualifies a/b/c for capture into the output register.
- y  output  WIDTH  combinational sum, (a+b+c) mod 2^WIDTH.
- x  output  1  combinational carry-out, bit WIDTH of a+b+c.
- y_q  output  WIDTH  registered sum.
- x_q  output  1  registered carry-out.
- out_valid  output  1  registered in_valid; marks y_q/x_q as fresh.

Behaviour:
- Combinational path: for each bit i, with carry k0 = c:
  - y[i] = a[i] ^ b[i] ^ k(i)
  - k(i+1) = (a[i]&b[i]) | (a[i]&k(i)) | (b[i]&k(i))
  - x = k(WIDTH)
- Combinational path has zero latency. y/x settle in the same delta as any input change, independent of clk, rst and in_valid.
- WIDTH=1 truth table (a b c -> y x):
  - 000->00, 001->10, 010->10, 011->01
  - 100->10, 101->01, 110->01, 111->11
- Registered path, on each rising clk edge with rst low:
  - if in_valid=1: y_q<=y, x_q<=x, out_valid<=1.
  - if in_valid=0: y_q/x_q hold their value, out_valid<=0.
- Latency of the registered path: 1 cycle from in_valid sampled high to out_valid high.
- Reset: rst=1 immediately (asynchronously) forces y_q=0, x_q=0, out_valid=0, and holds them while asserted. Combinational y/x keep following the inputs during reset.
- Reset deassertion: the first capture occurs on the first rising edge with rst low and in_valid high.
- Reset mid-operation: a pending capture is discarded, with no partial update.
- Overflow/wrap: all-ones + all-ones + 1 gives y = all-ones, x=1. Sum wraps modulo 2^WIDTH; carry-out is the only overflow indication.
- X/Z inputs: no special handling; the result is undefined.

Decomposition:
- No shared package needed.
- Optional localparam for the reset value of the registered outputs (zero).
- One natural sub-module: full_adder_bit, a 1-bit cell (a, b, cin -> s, cout).
- full_adder_bit is instantiated WIDTH times in a generate loop to form the ripple chain.
- Output register and valid flop live in the top.

Test Plan:
- WIDTH=1, sweep all 8 {a,b,c} combinations at 5 ns spacing -> y/x match the truth table above immediately, e.g. 011 -> y=0 x=1, 111 -> y=1 x=1.
- WIDTH=1, in_valid=1, a=1 b=0 c=1 -> after one rising edge y_q=0, x_q=1, out_valid=1. in_valid=0 next cycle -> out_valid=0, y_q/x_q held.
- WIDTH=8:
  - a=0xFF b=0x01 c=0 -> y=0x00 x=1.
  - a=0xFF b=0xFF c=1 -> y=0xFF x=1.
  - a=0x3C b=0x42 c=1 -> y=0x7F x=0.
- Assert rst asynchronously between edges while out_valid=1 and y_q nonzero -> y_q=0, x_q=0, out_valid=0 immediately. Combinational y/x remain correct throughout.
- Release rst with in_valid=1, a=b=1 (WIDTH=1), c=0 -> first edge after release gives y_q=0, x_q=1, out_valid=1.
- Back-to-back in_valid=1 for 4 cycles with changing operands -> each cycle's y_q/x_q equals the previous cycle's combinational y/x.
